// File: rtl/ws2812_pattern_source_if.sv
// Byte-request handshake between the ws2812b serial driver (master) and a pixel-data source (slave).
interface ws2812_pattern_source_if #(
  parameter int AW         = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  pixel_request;
  logic [AW-1:0]         pixel_address;
  logic                  pixel_ready;
  logic                  pixel_valid;
  logic [DATA_WIDTH-1:0] pixel_data;

  modport master (
    output pixel_request,
    output pixel_address,
    input  pixel_ready,
    input  pixel_valid,
    input  pixel_data
  );

  modport slave (
    input  pixel_request,
    input  pixel_address,
    output pixel_ready,
    output pixel_valid,
    output pixel_data
  );
endinterface

// File: rtl/ws2812_pattern_source.sv
// Palette/mode pixel source for ws2812b with intensity scaling and a rotating LED offset.
// Optional gamma stage enabled by defining WS2812_PATTERN_GAMMA_EN (adds one cycle of latency).
module ws2812_pattern_source #(
  parameter int CLOCK_HZ       = 12_000_000,
  parameter int NUMBER_OF_LEDS = 16,
  parameter int CHANNELS       = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int PALETTE_DEPTH  = 8,
  parameter int STEP_HZ        = 10
) (
  input  logic                                 clock,
  input  logic                                 reset,
  ws2812_pattern_source_if.slave               pix,
  input  logic [1:0]                           mode,
  input  logic [DATA_WIDTH-1:0]                intensity,
  input  logic                                 step,
  input  logic                                 direction,
  input  logic                                 auto_step_en,
  input  logic                                 pal_we,
  input  logic [$clog2(PALETTE_DEPTH)-1:0]     pal_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       pal_wdata,
  output logic [$clog2(NUMBER_OF_LEDS)-1:0]    offset
);

  localparam int AW        = $clog2(NUMBER_OF_LEDS * CHANNELS);
  localparam int LW        = $clog2(NUMBER_OF_LEDS);
  localparam int PW        = $clog2(PALETTE_DEPTH);
  localparam int EW        = CHANNELS * DATA_WIDTH;
  localparam int STEP_DIV  = CLOCK_HZ / STEP_HZ;
  localparam int TW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_PALETTE = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_GAMMA  = 2'd2,
    S_OUT    = 2'd3
  } state_t;

`ifdef WS2812_PATTERN_GAMMA_EN
  localparam state_t LAST_STAGE = S_GAMMA;
`else
  localparam state_t LAST_STAGE = S_LOOKUP;
`endif

  function automatic logic [EW-1:0] reset_entry(input int k);
    int code;
    code = (k + 1) % (1 << CHANNELS);
    reset_entry = {EW{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      reset_entry[c*DATA_WIDTH +: DATA_WIDTH] =
        (((code >> c) & 1) != 0) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end
  endfunction

  // 2*DATA_WIDTH+1-bit product keeps (c * (i + 1)) exact before the shift.
  function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] c,
                                                  input logic [DATA_WIDTH-1:0] i);
    logic [2*DATA_WIDTH:0] prod;
    prod = {{(DATA_WIDTH+1){1'b0}}, c} *
           ({{(DATA_WIDTH+1){1'b0}}, i} + {{(2*DATA_WIDTH){1'b0}}, 1'b1});
    return DATA_WIDTH'(prod >> DATA_WIDTH);
  endfunction

`ifdef WS2812_PATTERN_GAMMA_EN
  function automatic logic [DATA_WIDTH-1:0] gamma(input logic [DATA_WIDTH-1:0] s);
    logic [2*DATA_WIDTH:0] prod;
    prod = {{(DATA_WIDTH+1){1'b0}}, s} *
           ({{(DATA_WIDTH+1){1'b0}}, s} + {{(2*DATA_WIDTH){1'b0}}, 1'b1});
    return DATA_WIDTH'(prod >> DATA_WIDTH);
  endfunction
`endif

  logic [EW-1:0]         palette_r [PALETTE_DEPTH];
  state_t                state_r, state_next_s;
  logic                  ready_r, valid_r;
  logic [DATA_WIDTH-1:0] pixel_data_r;
  mode_t                 shadow_mode_r, mode_eff_s;
  logic [DATA_WIDTH-1:0] shadow_int_r;
  logic [LW-1:0]         frame_offset_r, offset_eff_s, offset_r;
  logic [TW-1:0]         timer_r;
  logic [DATA_WIDTH-1:0] s1_byte_r, s1_int_r, byte_s;
  logic [EW-1:0]         colour_s;
  logic [AW-1:0]         addr_s;
  logic [31:0]           led_s, ch_s, rot_s, pidx_s;
  logic                  accept_s, frame_start_s, in_range_s, tick_s, advance_s;
`ifdef WS2812_PATTERN_GAMMA_EN
  logic [DATA_WIDTH-1:0] s2_r;
`endif

  assign addr_s          = pix.pixel_address;
  assign accept_s        = pix.pixel_request && ready_r;
  assign frame_start_s   = (addr_s == AW'(0));
  assign pix.pixel_ready = ready_r;
  assign pix.pixel_valid = valid_r;
  assign pix.pixel_data  = pixel_data_r;
  assign offset          = offset_r;
  assign tick_s          = auto_step_en && (timer_r == TW'(STEP_DIV - 1));
  assign advance_s       = step || tick_s;

  // Address decode, rotation and colour selection for the request being accepted.
  always_comb begin
    mode_eff_s   = frame_start_s ? mode_t'(mode) : shadow_mode_r;
    offset_eff_s = frame_start_s ? offset_r : frame_offset_r;
    led_s        = 32'(addr_s) / 32'(CHANNELS);
    ch_s         = 32'(addr_s) % 32'(CHANNELS);
    in_range_s   = 32'(addr_s) < 32'(NUMBER_OF_LEDS * CHANNELS);
    rot_s        = (led_s + 32'(offset_eff_s)) % 32'(NUMBER_OF_LEDS);
    pidx_s       = rot_s % 32'(PALETTE_DEPTH);
    colour_s     = {EW{1'b0}};
    case (mode_eff_s)
      MODE_SOLID:   colour_s = palette_r[0];
      MODE_PALETTE: begin
        for (int k = 0; k < PALETTE_DEPTH; k++) begin
          colour_s = (pidx_s == 32'(k)) ? palette_r[k] : colour_s;
        end
      end
      MODE_CHASE:   colour_s = (rot_s == 32'd0) ? palette_r[0] : {EW{1'b0}};
      MODE_OFF:     colour_s = {EW{1'b0}};
      default:      colour_s = {EW{1'b0}};
    endcase
    byte_s = {DATA_WIDTH{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      byte_s = (ch_s == 32'(c)) ? colour_s[c*DATA_WIDTH +: DATA_WIDTH] : byte_s;
    end
    byte_s = in_range_s ? byte_s : {DATA_WIDTH{1'b0}};
  end

  // Request FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:   state_next_s = accept_s ? S_LOOKUP : S_IDLE;
`ifdef WS2812_PATTERN_GAMMA_EN
      S_LOOKUP: state_next_s = S_GAMMA;
`else
      S_LOOKUP: state_next_s = S_OUT;
`endif
      S_GAMMA:  state_next_s = S_OUT;
      S_OUT:    state_next_s = S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // FSM state and registered ready.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      ready_r <= (state_next_s == S_IDLE);
    end
  end

  // Writable palette, reloaded with the default colour table on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PALETTE_DEPTH; k++) begin
        palette_r[k] <= reset_entry(k);
      end
    end else if (pal_we) begin
      palette_r[pal_addr] <= pal_wdata;
    end
  end

  // Frame settings are frozen at the address-0 request so a frame is self-consistent.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_mode_r  <= MODE_OFF;
      shadow_int_r   <= {DATA_WIDTH{1'b0}};
      frame_offset_r <= {LW{1'b0}};
    end else if (accept_s && frame_start_s) begin
      shadow_mode_r  <= mode_t'(mode);
      shadow_int_r   <= intensity;
      frame_offset_r <= offset_r;
    end
  end

  // Stage 1: looked-up channel byte and the intensity it will be scaled by.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_byte_r <= {DATA_WIDTH{1'b0}};
      s1_int_r  <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      s1_byte_r <= byte_s;
      s1_int_r  <= frame_start_s ? intensity : shadow_int_r;
    end
  end

`ifdef WS2812_PATTERN_GAMMA_EN
  // Stage 2: scaled value ahead of the gamma curve.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_r <= {DATA_WIDTH{1'b0}};
    end else if (state_r == S_LOOKUP) begin
      s2_r <= scale(s1_byte_r, s1_int_r);
    end
  end
`endif

  // Output stage: one-cycle valid strobe, data held between strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r      <= 1'b0;
      pixel_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      valid_r <= (state_r == LAST_STAGE);
      if (state_r == LAST_STAGE) begin
`ifdef WS2812_PATTERN_GAMMA_EN
        pixel_data_r <= gamma(s2_r);
`else
        pixel_data_r <= scale(s1_byte_r, s1_int_r);
`endif
      end
    end
  end

  // Auto-step divider, parked at zero while disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_r <= {TW{1'b0}};
    end else if (!auto_step_en || tick_s) begin
      timer_r <= {TW{1'b0}};
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Pending offset; a manual step and a timer tick together still move one LED.
  always_ff @(posedge clock) begin
    if (reset) begin
      offset_r <= {LW{1'b0}};
    end else if (advance_s) begin
      if (direction) begin
        offset_r <= (offset_r == LW'(0)) ? LW'(NUMBER_OF_LEDS - 1) : offset_r - LW'(1);
      end else begin
        offset_r <= (offset_r == LW'(NUMBER_OF_LEDS - 1)) ? LW'(0) : offset_r + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ws2812_pattern_source.sv
// Directed bench for ws2812_pattern_source: 4 LEDs, GRB, 8-bit, 10-cycle auto-step period.
module tb_ws2812_pattern_source;

  localparam int N  = 4;
  localparam int C  = 3;
  localparam int DW = 8;
  localparam int PD = 8;
  localparam int AW = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [7:0]  intensity;
  logic        step, direction, auto_step_en, pal_we;
  logic [2:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [1:0]  offset;

  int checks   = 0;
  int failures = 0;

  ws2812_pattern_source_if #(.AW(AW), .DATA_WIDTH(DW)) pix ();

  ws2812_pattern_source #(
    .CLOCK_HZ(100), .NUMBER_OF_LEDS(N), .CHANNELS(C),
    .DATA_WIDTH(DW), .PALETTE_DEPTH(PD), .STEP_HZ(10)
  ) dut (
    .clock(clock), .reset(reset), .pix(pix), .mode(mode), .intensity(intensity),
    .step(step), .direction(direction), .auto_step_en(auto_step_en),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .offset(offset)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] inten;
    logic [3:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One request; watches 6 cycles after accept for the valid strobe.
  task automatic run_req(input logic [3:0] addr, output logic [7:0] data,
                         output int lat, output int nvalid);
    lat    = 0;
    nvalid = 0;
    data   = 8'h00;
    check("ready_before_req", 32'(pix.pixel_ready), 32'd1);
    pix.pixel_request = 1'b1;
    pix.pixel_address = addr;
    tick;
    pix.pixel_request = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (pix.pixel_valid) begin
        nvalid++;
        if (lat == 0) begin
          lat  = i;
          data = pix.pixel_data;
        end
      end
      tick;
    end
  endtask

  task automatic req_expect(input string name, input logic [1:0] m, input logic [7:0] inten,
                            input logic [3:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    int lat, nv;
    mode      = m;
    intensity = inten;
    run_req(addr, d, lat, nv);
    check(name, 32'(d), 32'(exp));
    check({name, "_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic pulse_step(input logic dir);
    direction = dir;
    step = 1'b1;
    tick;
    step = 1'b0;
  endtask

  task automatic add_vec(input logic [1:0] m, input logic [7:0] i, input logic [3:0] a,
                         input logic [7:0] e);
    vec_t v;
    v.mode = m; v.inten = i; v.addr = a; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] d;
    int lat, nv, nvalid;

    reset = 1'b1; mode = 2'd0; intensity = 8'h00; step = 1'b0; direction = 1'b0;
    auto_step_en = 1'b0; pal_we = 1'b0; pal_addr = 3'd0; pal_wdata = 24'h000000;
    pix.pixel_request = 1'b0; pix.pixel_address = 4'd0;

    // Palette scaling, intensity scaling/frame latch, out-of-range.
    add_vec(2'd1, 8'hFF, 4'd0,  8'hFF); add_vec(2'd1, 8'hFF, 4'd1,  8'h00);
    add_vec(2'd1, 8'hFF, 4'd2,  8'h00); add_vec(2'd1, 8'hFF, 4'd3,  8'h00);
    add_vec(2'd1, 8'hFF, 4'd4,  8'hFF); add_vec(2'd1, 8'hFF, 4'd5,  8'h00);
    add_vec(2'd1, 8'hFF, 4'd6,  8'hFF); add_vec(2'd1, 8'hFF, 4'd7,  8'hFF);
    add_vec(2'd1, 8'hFF, 4'd8,  8'h00); add_vec(2'd1, 8'hFF, 4'd9,  8'h00);
    add_vec(2'd1, 8'hFF, 4'd10, 8'h00); add_vec(2'd1, 8'hFF, 4'd11, 8'hFF);
    add_vec(2'd0, 8'h7F, 4'd0,  8'h7F); add_vec(2'd0, 8'h7F, 4'd1,  8'h00);
    add_vec(2'd0, 8'h7F, 4'd2,  8'h00); add_vec(2'd0, 8'hFF, 4'd3,  8'h7F);
    add_vec(2'd0, 8'hFF, 4'd0,  8'hFF); add_vec(2'd3, 8'hFF, 4'd3,  8'hFF);
    add_vec(2'd3, 8'hFF, 4'd0,  8'h00); add_vec(2'd0, 8'h40, 4'd0,  8'h40);
    add_vec(2'd0, 8'h00, 4'd0,  8'h00); add_vec(2'd0, 8'hFF, 4'd0,  8'hFF);
    add_vec(2'd0, 8'hFF, 4'd12, 8'h00); add_vec(2'd0, 8'hFF, 4'd15, 8'h00);

    tick; tick;
    reset = 1'b0;
    check("rst_ready",  32'(pix.pixel_ready), 32'd1);
    check("rst_valid",  32'(pix.pixel_valid), 32'd0);
    check("rst_data",   32'(pix.pixel_data),  32'd0);
    check("rst_offset", 32'(offset),          32'd0);
    // Shadow mode resets to OFF: a non-zero address before any frame start yields 0.
    req_expect("rst_shadow", 2'd1, 8'hFF, 4'd3, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      mode      = vecs[i].mode;
      intensity = vecs[i].inten;
      run_req(vecs[i].addr, d, lat, nv);
      check($sformatf("vec%0d_data", i),  32'(d),              32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i),   32'(lat),            32'd2);
      check($sformatf("vec%0d_nvalid", i), 32'(nv),            32'd1);
      check($sformatf("vec%0d_hold", i),  32'(pix.pixel_data), 32'(vecs[i].exp));
    end

    // Chase and offset wrap in both directions.
    req_expect("chase_led0", 2'd2, 8'hFF, 4'd0, 8'hFF);
    req_expect("chase_led1", 2'd2, 8'hFF, 4'd3, 8'h00);
    req_expect("chase_led3", 2'd2, 8'hFF, 4'd9, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      pulse_step(1'b0);
      check($sformatf("inc_step%0d", k), 32'(offset), 32'(k % 4));
    end
    pulse_step(1'b0);
    check("inc_to1", 32'(offset), 32'd1);
    req_expect("chase_off1_led0", 2'd2, 8'hFF, 4'd0, 8'h00);
    req_expect("chase_off1_led3", 2'd2, 8'hFF, 4'd9, 8'hFF);
    req_expect("pal_off1_g", 2'd1, 8'hFF, 4'd0, 8'h00);
    req_expect("pal_off1_r", 2'd1, 8'hFF, 4'd1, 8'hFF);
    pulse_step(1'b1);
    check("dec_to0", 32'(offset), 32'd0);
    pulse_step(1'b1);
    check("dec_wrap", 32'(offset), 32'd3);
    // A step mid-frame does not disturb the latched frame offset.
    req_expect("frame_off3_led0", 2'd2, 8'hFF, 4'd0, 8'h00);
    pulse_step(1'b0);
    check("inc_wrap", 32'(offset), 32'd0);
    req_expect("frame_off3_led1", 2'd2, 8'hFF, 4'd3, 8'hFF);
    req_expect("frame_off0_led0", 2'd2, 8'hFF, 4'd0, 8'hFF);

    // Manual step coinciding with the auto-step tick.
    direction = 1'b0;
    auto_step_en = 1'b1;
    repeat (9) tick;
    check("auto_no_early", 32'(offset), 32'd0);
    step = 1'b1;
    tick;
    step = 1'b0;
    check("simul_step", 32'(offset), 32'd1);
    repeat (9) tick;
    check("auto_wait", 32'(offset), 32'd1);
    tick;
    check("auto_tick", 32'(offset), 32'd2);
    auto_step_en = 1'b0;
    tick;

    // Second request held into cycle 1 must be ignored.
    mode = 2'd0; intensity = 8'hFF;
    pix.pixel_request = 1'b1; pix.pixel_address = 4'd0;
    tick;
    pix.pixel_address = 4'd1;
    check("busy_ready_c1", 32'(pix.pixel_ready), 32'd0);
    tick;
    pix.pixel_request = 1'b0;
    check("busy_valid_c2", 32'(pix.pixel_valid), 32'd1);
    check("busy_data_c2",  32'(pix.pixel_data),  32'hFF);
    check("busy_ready_c2", 32'(pix.pixel_ready), 32'd0);
    tick;
    check("busy_ready_c3", 32'(pix.pixel_ready), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 5; i++) begin
      if (pix.pixel_valid) nvalid++;
      tick;
    end
    check("busy_no_second_valid", 32'(nvalid), 32'd0);

    // Reset in cycle 1 drops the in-flight request.
    pix.pixel_request = 1'b1; pix.pixel_address = 4'd0;
    tick;
    pix.pixel_request = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("midrst_valid",  32'(pix.pixel_valid), 32'd0);
    check("midrst_ready",  32'(pix.pixel_ready), 32'd1);
    check("midrst_data",   32'(pix.pixel_data),  32'd0);
    check("midrst_offset", 32'(offset),          32'd0);
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      if (pix.pixel_valid) nvalid++;
      tick;
    end
    check("midrst_no_valid", 32'(nvalid), 32'd0);

    // Palette writes, including one landing mid-frame.
    pal_we = 1'b1; pal_addr = 3'd0; pal_wdata = 24'h123456;
    tick;
    pal_we = 1'b0;
    req_expect("palw_ch0", 2'd0, 8'hFF, 4'd0, 8'h56);
    req_expect("palw_ch1", 2'd0, 8'hFF, 4'd1, 8'h34);
    req_expect("palw_ch2", 2'd0, 8'hFF, 4'd2, 8'h12);
    pal_we = 1'b1; pal_wdata = 24'hABCDEF;
    tick;
    pal_we = 1'b0;
    req_expect("palw_midframe", 2'd0, 8'hFF, 4'd1, 8'hCD);
    req_expect("pal_entry3_b", 2'd1, 8'hFF, 4'd0, 8'hEF);
    req_expect("pal_entry3_blue", 2'd1, 8'hFF, 4'd11, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
